// File: rtl/ladybird_csr_access_unit.sv
// Zicsr initiator: legality checks, CSR file strobe, old-value capture and writeback response.
// Optional trace output is compiled in when LADYBIRD_CSR_ACCESS_TRACE_EN is defined.
module ladybird_csr_access_unit #(
  parameter int XLEN          = 32,
  parameter int TRACE_HART_ID = 0
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            flush_i,
  input  logic [1:0]      priv_mode_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_funct3_i,
  input  logic [11:0]     req_addr_i,
  input  logic [4:0]      req_rs1_idx_i,
  input  logic [XLEN-1:0] req_rs1_data_i,
  input  logic [4:0]      req_rd_idx_i,
  output logic [2:0]      csr_op_o,
  output logic            csr_valid_o,
  output logic [11:0]     csr_addr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [4:0]      resp_rd_idx_o,
  output logic            resp_we_o,
  output logic [XLEN-1:0] resp_data_o,
  output logic            resp_illegal_o
);

  // state  | meaning
  // IDLE   | waiting for a request
  // ACCESS | CSR file addressed, write strobe, old value sampled
  // RESP   | response held until accepted
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRWI = 3'b101;

  logic [1:0]      state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [11:0]     addr_q, addr_d;
  logic [4:0]      rs1_idx_q, rs1_idx_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [4:0]      rd_idx_q, rd_idx_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic            resp_illegal_q, resp_illegal_d;
  logic            resp_we_q, resp_we_d;

  logic            req_fire;
  logic            resp_fire;
  logic            write_eff;
  logic            illegal;
  logic            bad_funct3;
  logic            ro_write;
  logic            priv_fault;
  logic [XLEN-1:0] operand;

  assign req_ready_o = (state_q == ST_IDLE) & ~flush_i & nrst;
  assign req_fire    = req_valid_i & req_ready_o;
  assign resp_fire   = resp_valid_o & resp_ready_i;

  // Set/clear forms with a zero source are pure reads and must not strobe the CSR file.
  assign write_eff  = (funct3_q == F3_CSRRW) | (funct3_q == F3_CSRRWI) | (rs1_idx_q != 5'd0);
  assign bad_funct3 = (funct3_q[1:0] == 2'b00);
  assign ro_write   = write_eff & (addr_q[11:10] == 2'b11);
  assign priv_fault = (priv_mode_i < addr_q[9:8]);
  assign illegal    = bad_funct3 | ro_write | priv_fault;

  assign operand = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_data_q;

  always_comb begin
    state_d        = state_q;
    funct3_d       = funct3_q;
    addr_d         = addr_q;
    rs1_idx_d      = rs1_idx_q;
    rs1_data_d     = rs1_data_q;
    rd_idx_d       = rd_idx_q;
    resp_data_d    = resp_data_q;
    resp_illegal_d = resp_illegal_q;
    resp_we_d      = resp_we_q;

    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          funct3_d   = req_funct3_i;
          addr_d     = req_addr_i;
          rs1_idx_d  = req_rs1_idx_i;
          rs1_data_d = req_rs1_data_i;
          rd_idx_d   = req_rd_idx_i;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // The write lands on this same edge, so the sampled value is the pre-write one.
        resp_data_d    = csr_rdata_i;
        resp_illegal_d = illegal;
        resp_we_d      = ~illegal & (rd_idx_q != 5'd0);
        state_d        = ST_RESP;
      end
      ST_RESP: begin
        if (resp_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (flush_i) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q        <= ST_IDLE;
      funct3_q       <= 3'd0;
      addr_q         <= 12'd0;
      rs1_idx_q      <= 5'd0;
      rs1_data_q     <= '0;
      rd_idx_q       <= 5'd0;
      resp_data_q    <= '0;
      resp_illegal_q <= 1'b0;
      resp_we_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      funct3_q       <= funct3_d;
      addr_q         <= addr_d;
      rs1_idx_q      <= rs1_idx_d;
      rs1_data_q     <= rs1_data_d;
      rd_idx_q       <= rd_idx_d;
      resp_data_q    <= resp_data_d;
      resp_illegal_q <= resp_illegal_d;
      resp_we_q      <= resp_we_d;
    end
  end

  assign csr_op_o    = funct3_q;
  assign csr_addr_o  = addr_q;
  assign csr_wdata_o = operand;
  assign csr_valid_o = (state_q == ST_ACCESS) & write_eff & ~illegal & ~flush_i & nrst;

  assign resp_valid_o   = (state_q == ST_RESP);
  assign resp_rd_idx_o  = rd_idx_q;
  assign resp_data_o    = resp_data_q;
  assign resp_we_o      = resp_we_q;
  assign resp_illegal_o = resp_illegal_q;

`ifdef LADYBIRD_CSR_ACCESS_TRACE_EN
  function automatic string op_name(input logic [2:0] f3);
    case (f3)
      3'b001:  op_name = "csrrw";
      3'b010:  op_name = "csrrs";
      3'b011:  op_name = "csrrc";
      3'b101:  op_name = "csrrwi";
      3'b110:  op_name = "csrrsi";
      3'b111:  op_name = "csrrci";
      default: op_name = "bad";
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (nrst && (state_q == ST_ACCESS) && !flush_i) begin
      $display("hart%0d csr %s addr %h w %h r %h%s", TRACE_HART_ID, op_name(funct3_q),
               addr_q, operand, csr_rdata_i, illegal ? " ILLEGAL" : "");
    end
  end
`endif

endmodule

// File: tb/tb_ladybird_csr_access_unit.sv
// Directed bench for ladybird_csr_access_unit with hand-computed expectations.
module tb_ladybird_csr_access_unit;

  logic        clk = 1'b0;
  logic        nrst;
  logic        flush;
  logic [1:0]  priv_mode;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [4:0]  req_rs1_idx;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_rd_idx;
  logic [2:0]  csr_op;
  logic        csr_valid;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_rd_idx;
  logic        resp_we;
  logic [31:0] resp_data;
  logic        resp_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ladybird_csr_access_unit #(.XLEN(32), .TRACE_HART_ID(0)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .flush_i        (flush),
    .priv_mode_i    (priv_mode),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_funct3_i   (req_funct3),
    .req_addr_i     (req_addr),
    .req_rs1_idx_i  (req_rs1_idx),
    .req_rs1_data_i (req_rs1_data),
    .req_rd_idx_i   (req_rd_idx),
    .csr_op_o       (csr_op),
    .csr_valid_o    (csr_valid),
    .csr_addr_o     (csr_addr),
    .csr_wdata_o    (csr_wdata),
    .csr_rdata_i    (csr_rdata),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_rd_idx_o  (resp_rd_idx),
    .resp_we_o      (resp_we),
    .resp_data_o    (resp_data),
    .resp_illegal_o (resp_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request in IDLE, checks the ACCESS cycle, and leaves the unit in RESP.
  task automatic issue(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [4:0] rs1, input logic [31:0] rs1d, input logic [4:0] rd,
                       input logic [31:0] rdata, input logic exp_cv, input logic [31:0] exp_wd);
    chk({tag, " req_ready idle"}, {31'd0, req_ready}, 32'd1);
    req_funct3   = f3;
    req_addr     = addr;
    req_rs1_idx  = rs1;
    req_rs1_data = rs1d;
    req_rd_idx   = rd;
    req_valid    = 1'b1;
    step();
    req_valid = 1'b0;
    csr_rdata = rdata;
    #1;
    chk({tag, " csr_valid"}, {31'd0, csr_valid}, {31'd0, exp_cv});
    chk({tag, " csr_wdata"}, csr_wdata, exp_wd);
    chk({tag, " csr_addr"}, {20'd0, csr_addr}, {20'd0, addr});
    chk({tag, " req_ready access"}, {31'd0, req_ready}, 32'd0);
    step();
    csr_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic check_resp(input string tag, input logic [31:0] data, input logic [4:0] rd,
                            input logic we, input logic ill);
    chk({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, " csr_valid resp"}, {31'd0, csr_valid}, 32'd0);
    chk({tag, " resp_data"}, resp_data, data);
    chk({tag, " resp_rd_idx"}, {27'd0, resp_rd_idx}, {27'd0, rd});
    chk({tag, " resp_we"}, {31'd0, resp_we}, {31'd0, we});
    chk({tag, " resp_illegal"}, {31'd0, resp_illegal}, {31'd0, ill});
  endtask

  task automatic handshake(input string tag);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({tag, " resp_valid after hs"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, " req_ready after hs"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    nrst = 1'b0; flush = 1'b0; priv_mode = 2'd3; req_valid = 1'b0;
    req_funct3 = 3'd0; req_addr = 12'd0; req_rs1_idx = 5'd0; req_rs1_data = 32'd0;
    req_rd_idx = 5'd0; csr_rdata = 32'd0; resp_ready = 1'b0;

    step(); step(); step();
    chk("rst req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst csr_valid", {31'd0, csr_valid}, 32'd0);
    chk("rst resp_illegal", {31'd0, resp_illegal}, 32'd0);
    chk("rst resp_data", resp_data, 32'd0);
    nrst = 1'b1;
    #1;

    // M-mode CSRRW mtvec
    issue("rw305", 3'b001, 12'h305, 5'd1, 32'h8000_0000, 5'd5, 32'h0, 1'b1, 32'h8000_0000);
    check_resp("rw305", 32'h0, 5'd5, 1'b1, 1'b0);
    handshake("rw305");

    // CSRRS x0 of cycle: read only, no strobe
    issue("rs_c00", 3'b010, 12'hC00, 5'd0, 32'hFFFF_FFFF, 5'd3, 32'h1234, 1'b0, 32'hFFFF_FFFF);
    check_resp("rs_c00", 32'h1234, 5'd3, 1'b1, 1'b0);
    handshake("rs_c00");

    // CSRRWI to read-only space: zimm still forwarded, write suppressed
    issue("rwi_c01", 3'b101, 12'hC01, 5'd7, 32'hFFFF_FFFF, 5'd4, 32'h55, 1'b0, 32'h7);
    check_resp("rwi_c01", 32'h55, 5'd4, 1'b0, 1'b1);
    handshake("rwi_c01");

    // U-mode read of mstatus
    priv_mode = 2'd0;
    issue("u_300", 3'b010, 12'h300, 5'd0, 32'h0, 5'd6, 32'h1800, 1'b0, 32'h0);
    check_resp("u_300", 32'h1800, 5'd6, 1'b0, 1'b1);
    handshake("u_300");

    // S-mode CSRRSI to sscratch-range address is legal
    priv_mode = 2'd1;
    issue("s_140", 3'b110, 12'h140, 5'd3, 32'hAAAA_AAAA, 5'd9, 32'hCAFE, 1'b1, 32'h3);
    check_resp("s_140", 32'hCAFE, 5'd9, 1'b1, 1'b0);
    handshake("s_140");

    // Reserved funct3 100 is illegal even with rs1 nonzero
    priv_mode = 2'd3;
    issue("f3_100", 3'b100, 12'h340, 5'd2, 32'h0, 5'd8, 32'h11, 1'b0, 32'h2);
    check_resp("f3_100", 32'h11, 5'd8, 1'b0, 1'b1);
    handshake("f3_100");

    // CSRRC with rd=x0: writes, but no register writeback
    issue("rc_rd0", 3'b011, 12'h340, 5'd2, 32'h0000_00F0, 5'd0, 32'h77, 1'b1, 32'h0000_00F0);
    check_resp("rc_rd0", 32'h77, 5'd0, 1'b0, 1'b0);

    // Backpressure on the last response
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp resp_data", resp_data, 32'h77);
      chk("bp req_ready", {31'd0, req_ready}, 32'd0);
    end
    handshake("bp");

    // Flush during ACCESS kills the write and the response
    req_funct3 = 3'b001; req_addr = 12'h305; req_rs1_idx = 5'd1;
    req_rs1_data = 32'h1234_5678; req_rd_idx = 5'd5; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush csr_valid", {31'd0, csr_valid}, 32'd0);
    chk("flush req_ready", {31'd0, req_ready}, 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("flush resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("flush req_ready idle", {31'd0, req_ready}, 32'd1);
    step();
    chk("flush resp_valid later", {31'd0, resp_valid}, 32'd0);

    // Reset mid-operation issues no write
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    nrst = 1'b0;
    #1;
    chk("nrst csr_valid", {31'd0, csr_valid}, 32'd0);
    step();
    nrst = 1'b1;
    #1;
    chk("nrst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("nrst req_ready", {31'd0, req_ready}, 32'd1);
    chk("nrst resp_data", resp_data, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ladybird_csr_access_unit.md
Name: ladybird_csr_access_unit

Overview:
Initiator side of the hart's CSR access port. It accepts one decoded Zicsr instruction at a time from the execute stage and performs the architectural legality checks. It drives the CSR file's op/valid/addr/data port, captures the old CSR value, and returns a register-writeback response through a valid/ready handshake. It sits between the execute stage and the CSR file, and between the execute stage and the writeback/trap logic.

Parameters:
XLEN, 32, datapath width; taken from ladybird_config.
TRACE_HART_ID, 0, hart index printed by the optional trace.

Ports:
clk  input  1  clock
nrst  input  1  reset, synchronous, active-low
flush  input  1  pipeline kill; abandons the in-flight instruction
priv_mode  input  2  current privilege (U=0, S=1, M=3)
req_valid  input  1  request present
req_ready  output  1  unit can accept
req_funct3  input  3  Zicsr funct3
req_addr  input  12  CSR address
req_rs1_idx  input  5  rs1 index, or zimm for immediate forms
req_rs1_data  input  XLEN  rs1 value
req_rd_idx  input  5  destination register
csr_op  output  3  funct3 forwarded to the CSR file
csr_valid  output  1  single-cycle write strobe
csr_addr  output  12  CSR address
csr_wdata  output  XLEN  operand (rs1 value or zero-extended zimm)
csr_rdata  input  XLEN  combinational read data from the CSR file
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts the response
resp_rd_idx  output  5  destination register
resp_we  output  1  register write enable
resp_data  output  XLEN  old CSR value
resp_illegal  output  1  illegal-instruction exception

Behaviour:
- States: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values: all request and response registers are 0; csr_valid=0; resp_valid=0; resp_illegal=0; req_ready=0 while nrst=0.
- req_ready = (state==IDLE) & ~flush.
- IDLE: on req_valid & req_ready, latch funct3, addr, rs1_idx, rs1_data and rd_idx, then go to ACCESS.
- ACCESS lasts exactly 1 cycle:
  - csr_addr, csr_op and csr_wdata are driven from the latched fields.
  - csr_wdata = funct3[2] ? {zeros, rs1_idx} : rs1_data.
  - csr_rdata is sampled into resp_data at the end of the cycle. Because the write lands on the same edge, resp_data holds the old value.
  - Next state is RESP.
- write_eff = (funct3 is CSRRW or CSRRWI) | (rs1_idx != 0).
- illegal = any of:
  - funct3 in {000, 100};
  - write_eff & (addr[11:10]==2'b11);
  - priv_mode < addr[9:8].
- csr_valid = (state==ACCESS) & write_eff & ~illegal & ~flush. It is never asserted in any other state.
- CSRRS/CSRRC/CSRRSI/CSRRCI with a zero source produce no csr_valid; the read still occurs.
- RESP:
  - resp_valid=1.
  - resp_illegal = illegal.
  - resp_we = ~illegal & (rd_idx != 0).
  - Outputs hold stable until resp_ready. On resp_valid & resp_ready, go to IDLE. A new request can be accepted on the following cycle.
- Latency: accept at cycle T, csr_valid at T+1, resp_valid from T+2. Throughput is at most 1 instruction per 3 cycles.
- flush has priority over every transition. In any state it forces IDLE on the next edge with no csr_valid and no response. A flush asserted during ACCESS suppresses the CSR write.
- nrst low mid-operation aborts it; no write is issued.

Optional Feature:
LADYBIRD_CSR_ACCESS_TRACE_EN
- Defined: on each ACCESS cycle without flush, $display prints:
  - "hart<TRACE_HART_ID> csr <op> addr <hex> w <hex> r <hex>";
  - an "ILLEGAL" suffix when illegal=1.
- Undefined: no trace logic and no simulation-only signals are compiled in.

Test Plan:
- M-mode CSRRW: addr 0x305, rs1_data 0x80000000, rd=5, with the CSR returning 0x0 -> csr_valid pulse at T+1 with csr_wdata 0x80000000; response resp_data 0x0, resp_we=1, resp_rd_idx=5, resp_illegal=0.
- CSRRS with rs1_idx=0 on addr 0xC00, rd=3, with csr_rdata 0x1234 -> no csr_valid; resp_data 0x1234; resp_we=1.
- CSRRWI zimm=7 to read-only addr 0xC01 -> no csr_valid; resp_illegal=1; resp_we=0.
- priv_mode=0 with CSRRS x0 on addr 0x300 -> resp_illegal=1; csr_valid=0.
- Backpressure: resp_ready held 0 for 4 cycles -> resp_valid and resp_data stable, req_ready=0; after the handshake, req_ready=1 the next cycle.
- flush asserted in ACCESS for CSRRW to 0x305 -> csr_valid=0, no resp_valid, state IDLE next cycle.
